xy_switch_alloc: RTL and testbench

- Parametrised successor to the 5-port table-routed router core.
- Computes dimension-ordered (XY or YX) routes from destination coordinates in each item, so no routing-table file is needed.
- Arbitrates each output with a registered round-robin pointer and drives outputs from a registered crossbar stage.
- Discards and counts illegal U-turn items. Sits between the per-port rx FIFOs and the serial tx units of one mesh node.

---
 rtl/xy_switch_alloc_if.sv | 12 +
 rtl/xy_switch_alloc.sv | 80 ++++++++
 tb/tb_xy_switch_alloc.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/xy_switch_alloc_if.sv
// xy_switch_alloc_if: the rx-FIFO heads and tx-unit handshake of one 5-port mesh node.
interface xy_switch_alloc_if #(parameter int DATA_W = 16, parameter int ERR_W = 8);
  logic [5*DATA_W-1:0] in_item;
  logic [4:0] in_empty;
  logic [4:0] in_read;
  logic [5*DATA_W-1:0] out_item;
  logic [4:0] out_ena;
  logic [4:0] out_busy;
  logic [ERR_W-1:0] err_cnt;
  modport master (input in_item, in_empty, out_busy, output in_read, out_item, out_ena, err_cnt);
  modport slave (output in_item, in_empty, out_busy, input in_read, out_item, out_ena, err_cnt);
endinterface

// File: rtl/xy_switch_alloc.sv
// xy_switch_alloc: dimension-ordered routing, per-output round-robin arbitration and a registered crossbar.
module xy_switch_alloc #(
  parameter int DATA_W = 16,
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int MODE = 0,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic reset,
  xy_switch_alloc_if.master bus
);
  localparam logic [X_W-1:0] MX = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY = Y_W'(MY_Y);
  logic [DATA_W-1:0] item [5];
  logic [2:0] route [5];
  logic [2:0] gnt_id [5];
  logic [2:0] ptr [5];
  logic [4:0] uturn, read, gnt_v, ena_q;
  logic [2:0] cand;
  logic [5*DATA_W-1:0] item_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W+2:0] err_sum;
  function automatic logic [2:0] wrap(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    return 3'(s >= 5 ? s - 5 : s);
  endfunction
  for (genvar p = 0; p < 5; p++) begin : g_in
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic [2:0] xd, yd;
    assign item[p] = bus.in_item[p*DATA_W +: DATA_W];
    assign dx = item[p][X_W-1:0];
    assign dy = item[p][X_W+Y_W-1:X_W];
    assign xd = dx > MX ? 3'd2 : dx < MX ? 3'd4 : 3'd0;
    assign yd = dy > MY ? 3'd1 : dy < MY ? 3'd3 : 3'd0;
    assign route[p] = MODE != 0 ? (yd != 3'd0 ? yd : xd) : (xd != 3'd0 ? xd : yd);
    assign uturn[p] = p != 0 && !bus.in_empty[p] && route[p] == 3'(p);
  end
  // A U-turn item is popped and dropped; it never raises a request.
  always_comb begin
    gnt_v = '0;
    read = uturn;
    cand = '0;
    for (int o = 0; o < 5; o++) begin
      gnt_id[o] = '0;
      for (int k = 0; k < 5; k++) begin
        cand = wrap(ptr[o], k);
        if (!gnt_v[o] && !bus.out_busy[o] && !ena_q[o] && !bus.in_empty[cand] && !uturn[cand] && route[cand] == 3'(o)) begin
          gnt_v[o] = 1'b1;
          gnt_id[o] = cand;
          read[cand] = 1'b1;
        end
      end
    end
  end
  assign err_sum = {3'b0, err_q} + (ERR_W+3)'($countones(uturn));
  assign bus.in_read = {5{reset}} & read;
  assign bus.out_item = item_q;
  assign bus.out_ena = ena_q;
  assign bus.err_cnt = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ena_q <= '0;
      item_q <= '0;
      err_q <= '0;
      for (int o = 0; o < 5; o++) ptr[o] <= '0;
    end else begin
      ena_q <= gnt_v;
      err_q <= |err_sum[ERR_W+2:ERR_W] ? '1 : err_sum[ERR_W-1:0];
      for (int o = 0; o < 5; o++)
        if (gnt_v[o]) begin
          item_q[o*DATA_W +: DATA_W] <= item[gnt_id[o]];
          ptr[o] <= gnt_id[o] == 3'd4 ? 3'd0 : gnt_id[o] + 3'd1;
        end
    end
endmodule

// File: tb/tb_xy_switch_alloc.sv
// tb_xy_switch_alloc: directed checks of routing, round-robin, U-turn counting, busy gating and reset.
module tb_xy_switch_alloc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] it [5];
  logic [15:0] it1 [5];
  int seq [5] = '{0, 1, 3, 4, 0};
  xy_switch_alloc_if #(.DATA_W(16), .ERR_W(8)) bus ();
  xy_switch_alloc_if #(.DATA_W(16), .ERR_W(8)) bus1 ();
  assign bus.in_item = {it[4], it[3], it[2], it[1], it[0]};
  assign bus1.in_item = {it1[4], it1[3], it1[2], it1[1], it1[0]};
  xy_switch_alloc #(.DATA_W(16), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1), .MODE(0), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  xy_switch_alloc #(.DATA_W(16), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1), .MODE(1), .ERR_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      it[i] = 16'h0;
      it1[i] = 16'h0;
    end
    bus.out_busy = 5'b0;
    bus1.out_busy = 5'b0;
    bus1.in_empty = 5'b11111;
    it[0] = 16'h0AB9;
    bus.in_empty = 5'b11110;
    tick();
    tick();
    chk("rst_read", bus.in_read, 5'b0);
    chk("rst_ena", bus.out_ena, 5'b0);
    chk("rst_item", {31'b0, |bus.out_item}, 32'd0);
    chk("rst_err", bus.err_cnt, 8'd0);
    bus.in_empty = 5'b11111;
    reset = 1'b1;
    tick();
    // LOCAL -> NORTH, one-cycle latency
    bus.in_empty = 5'b11110;
    #1 chk("north_read", bus.in_read, 5'b00001);
    tick();
    bus.in_empty = 5'b11111;
    chk("north_ena", bus.out_ena, 5'b00010);
    chk("north_item", bus.out_item[31:16], 16'h0AB9);
    tick();
    chk("north_ena_off", bus.out_ena, 5'b0);
    chk("north_hold", bus.out_item[31:16], 16'h0AB9);
    // round-robin on EAST
    it[0] = 16'h0006;
    it[1] = 16'h0106;
    it[3] = 16'h0306;
    it[4] = 16'h0406;
    bus.in_empty = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_read", bus.in_read, 32'd1 << seq[i]);
      tick();
      chk("rr_ena", bus.out_ena, 5'b00100);
      chk("rr_item", bus.out_item[47:32], it[seq[i]]);
      chk("rr_gap", bus.in_read, 5'b0);
      tick();
    end
    bus.in_empty = 5'b11111;
    tick();
    bus.in_empty = 5'b10110;
    #1 chk("rr_resume", bus.in_read, 5'b01000);
    tick();
    bus.in_empty = 5'b11111;
    chk("rr_resume_item", bus.out_item[47:32], 16'h0306);
    tick();
    // U-turn on EAST with saturation
    it[2] = 16'h0003;
    bus.in_empty = 5'b11011;
    #1 chk("uturn_read", bus.in_read, 5'b00100);
    tick();
    chk("uturn_ena", bus.out_ena, 5'b0);
    chk("uturn_err1", bus.err_cnt, 8'd1);
    repeat (253) tick();
    chk("uturn_err254", bus.err_cnt, 8'd254);
    tick();
    chk("uturn_err255", bus.err_cnt, 8'd255);
    repeat (45) tick();
    chk("uturn_sat", bus.err_cnt, 8'd255);
    chk("uturn_ena_sat", bus.out_ena, 5'b0);
    bus.in_empty = 5'b11111;
    tick();
    // dest (0,0): XY -> WEST, YX -> SOUTH
    it[0] = 16'h0050;
    it1[0] = 16'h0050;
    bus.in_empty = 5'b11110;
    bus1.in_empty = 5'b11110;
    #1 chk("xy_read", bus.in_read, 5'b00001);
    chk("yx_read", bus1.in_read, 5'b00001);
    tick();
    bus.in_empty = 5'b11111;
    bus1.in_empty = 5'b11111;
    chk("xy_ena", bus.out_ena, 5'b10000);
    chk("xy_item", bus.out_item[79:64], 16'h0050);
    chk("yx_ena", bus1.out_ena, 5'b01000);
    chk("yx_item", bus1.out_item[63:48], 16'h0050);
    tick();
    // busy gating on EAST
    it[0] = 16'h0006;
    bus.out_busy = 5'b00100;
    bus.in_empty = 5'b11100;
    for (int i = 0; i < 10; i++) begin
      #1 chk("busy_read", bus.in_read, 5'b0);
      chk("busy_ena", bus.out_ena, 5'b0);
      tick();
    end
    bus.out_busy = 5'b0;
    #1 chk("busy_drop", bus.in_read, 5'b00001);
    tick();
    chk("busy_ena1", bus.out_ena, 5'b00100);
    chk("busy_item1", bus.out_item[47:32], 16'h0006);
    #1 chk("busy_gap", bus.in_read, 5'b0);
    tick();
    #1 chk("busy_next", bus.in_read, 5'b00010);
    tick();
    bus.in_empty = 5'b11111;
    chk("busy_item2", bus.out_item[47:32], 16'h0106);
    tick();
    // reset while SOUTH strobe is active
    it[0] = 16'h0201;
    bus.in_empty = 5'b11110;
    #1 chk("south_read", bus.in_read, 5'b00001);
    tick();
    chk("south_ena", bus.out_ena, 5'b01000);
    reset = 1'b0;
    #1 chk("mid_rst_ena", bus.out_ena, 5'b0);
    chk("mid_rst_item", {31'b0, |bus.out_item}, 32'd0);
    chk("mid_rst_err", bus.err_cnt, 8'd0);
    chk("mid_rst_read", bus.in_read, 5'b0);
    bus.in_empty = 5'b11111;
    tick();
    reset = 1'b1;
    tick();
    it[0] = 16'h0006;
    bus.in_empty = 5'b00100;
    #1 chk("rst_ptr", bus.in_read, 5'b00001);
    tick();
    bus.in_empty = 5'b11111;
    chk("rst_ptr_item", bus.out_item[47:32], 16'h0006);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
